// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and de-glitches the PS/2 pins, frames
// 11-bit device-to-host words, and folds E0/F0 prefixes into single key events.
module ps2_keyboard_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       make,
    output logic       extended,
    output logic       keycode_ready,
    output logic       frame_error
);

    typedef enum logic [0:0] {StIdle, StRecv} state_t;

    localparam logic [7:0]  FiltMax = 8'(FILTER_LEN - 1);
    localparam logic [31:0] ToMax   = 32'(TIMEOUT_CYCLES);

    logic       clk_meta, clk_sync;
    logic       data_meta, data_sync;
    logic [7:0] filt_cnt;
    logic       filt_clk;
    logic       filt_prev;
    logic       strobe;

    state_t      state;
    logic [3:0]  bit_idx;
    logic [7:0]  shift;
    logic        parity;
    logic [31:0] to_cnt;
    logic        byte_valid;

    logic        ext_flag;
    logic        brk_flag;

    // Two-flop synchronisers; idle-high reset so release never looks like an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    // Glitch filter: the filtered clock follows only after FILTER_LEN stable samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_cnt <= 8'd0;
            filt_clk <= 1'b1;
        end else if (clk_sync == filt_clk) begin
            filt_cnt <= 8'd0;
        end else if (filt_cnt == FiltMax) begin
            filt_clk <= clk_sync;
            filt_cnt <= 8'd0;
        end else begin
            filt_cnt <= filt_cnt + 8'd1;
        end
    end

    // Registered one-cycle strobe on each falling edge of the filtered clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_prev <= 1'b1;
            strobe    <= 1'b0;
        end else begin
            filt_prev <= filt_clk;
            strobe    <= filt_prev & ~filt_clk;
        end
    end

    // Frame FSM: start/data/parity/stop collection with a mid-frame inactivity timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= StIdle;
            bit_idx     <= 4'd0;
            shift       <= 8'd0;
            parity      <= 1'b0;
            to_cnt      <= 32'd0;
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
            unique case (state)
                StIdle: begin
                    to_cnt <= 32'd0;
                    if (strobe && !data_sync) begin
                        state   <= StRecv;
                        bit_idx <= 4'd1;
                        parity  <= 1'b0;
                    end
                end
                StRecv: begin
                    // A strobe takes priority over an expiring timeout.
                    if (strobe) begin
                        to_cnt <= 32'd0;
                        if (bit_idx <= 4'd8) begin
                            shift   <= {data_sync, shift[7:1]};
                            parity  <= parity ^ data_sync;
                            bit_idx <= bit_idx + 4'd1;
                        end else if (bit_idx == 4'd9) begin
                            parity  <= parity ^ data_sync;
                            bit_idx <= bit_idx + 4'd1;
                        end else begin
                            state <= StIdle;
                            // Odd parity over data+parity means the running XOR is 1.
                            if (parity && data_sync) begin
                                byte_valid <= 1'b1;
                            end else begin
                                frame_error <= 1'b1;
                            end
                        end
                    end else if (to_cnt == ToMax) begin
                        frame_error <= 1'b1;
                        state       <= StIdle;
                        to_cnt      <= 32'd0;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Scan-code decoder: prefixes set flags, any other byte emits one key event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            keycode       <= 8'h00;
            make          <= 1'b0;
            extended      <= 1'b0;
            keycode_ready <= 1'b0;
            ext_flag      <= 1'b0;
            brk_flag      <= 1'b0;
        end else begin
            keycode_ready <= 1'b0;
            if (frame_error) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (byte_valid) begin
                if (shift == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (shift == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
                    keycode       <= shift;
                    make          <= ~brk_flag;
                    extended      <= ext_flag;
                    keycode_ready <= 1'b1;
                    ext_flag      <= 1'b0;
                    brk_flag      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: frames are bit-banged on the pins and
// each expected event (with its exact cycle) is queued before the DUT emits it.
module tb_ps2_keyboard_rx;

    localparam int unsigned FL = 8;
    localparam int unsigned TO = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode;
    logic       make;
    logic       extended;
    logic       keycode_ready;
    logic       frame_error;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        bit         is_err;
        int         at;
        logic [7:0] kc;
        logic       mk;
        logic       ex;
    } exp_t;

    exp_t sb[$];
    logic ext_m = 1'b0;
    logic brk_m = 1'b0;

    ps2_keyboard_rx #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .keycode      (keycode),
        .make         (make),
        .extended     (extended),
        .keycode_ready(keycode_ready),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Wait n rising edges, then settle 1 time unit before driving.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference decoder: queue what the stop bit at cycle s should produce.
    task automatic model_byte(input logic [7:0] b, input logic bad, input int s);
        exp_t e;
        if (bad) begin
            e = '{is_err: 1'b1, at: s + 1, kc: 8'h00, mk: 1'b0, ex: 1'b0};
            sb.push_back(e);
            ext_m = 1'b0;
            brk_m = 1'b0;
        end else if (b == 8'hE0) begin
            ext_m = 1'b1;
        end else if (b == 8'hF0) begin
            brk_m = 1'b1;
        end else begin
            e = '{is_err: 1'b0, at: s + 2, kc: b, mk: ~brk_m, ex: ext_m};
            sb.push_back(e);
            ext_m = 1'b0;
            brk_m = 1'b0;
        end
    endtask

    // One PS/2 bit: data set while clock high, 20-cycle low phase.
    task automatic drive_bit(input logic b, input logic last, input logic [7:0] byt,
                             input logic bad, output int fall);
        ps2_data = b;
        step(10);
        ps2_clk = 1'b0;
        fall = cyc;
        if (last) model_byte(byt, bad, cyc + FL + 3);
        step(20);
        ps2_clk = 1'b1;
        step(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad);
        logic [10:0] bits;
        int f;
        bits = {1'b1, ~(^b) ^ bad, b, 1'b0};
        for (int i = 0; i < 11; i++) drive_bit(bits[i], i == 10, b, bad, f);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_keycode"}, 32'(keycode), 32'h0);
        check_eq({tag, "_make"}, 32'(make), 32'h0);
        check_eq({tag, "_extended"}, 32'(extended), 32'h0);
        check_eq({tag, "_ready"}, 32'(keycode_ready), 32'h0);
        check_eq({tag, "_error"}, 32'(frame_error), 32'h0);
    endtask

    // Output monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (keycode_ready || frame_error) begin
            check_eq("pulse_exclusive", 32'(keycode_ready & frame_error), 32'h0);
            if (sb.size() == 0) begin
                check_eq("unexpected_event", 32'({keycode_ready, frame_error}), 32'h0);
            end else begin
                e = sb.pop_front();
                check_eq("event_kind_err", 32'(frame_error), 32'(e.is_err));
                check_eq("event_cycle", 32'(cyc), 32'(e.at));
                if (!e.is_err) begin
                    check_eq("keycode", 32'(keycode), 32'(e.kc));
                    check_eq("make", 32'(make), 32'(e.mk));
                    check_eq("extended", 32'(extended), 32'(e.ex));
                end
            end
        end
    end

    initial begin
        int f;
        // 1: reset, then a plain make code.
        step(5);
        check_idle_outputs("reset");
        reset = 1'b1;
        step(5);
        send_frame(8'h1C, 1'b0);
        // 2: break code.
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        // 3: extended make, extended break, plain make.
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        send_frame(8'h5A, 1'b0);
        // 4: parity error clears a pending break prefix.
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b1);
        send_frame(8'h5A, 1'b0);
        // 5: abandoned frame after start + 4 data bits.
        drive_bit(1'b0, 1'b0, 8'h00, 1'b0, f);
        drive_bit(1'b1, 1'b0, 8'h00, 1'b0, f);
        drive_bit(1'b0, 1'b0, 8'h00, 1'b0, f);
        drive_bit(1'b1, 1'b0, 8'h00, 1'b0, f);
        drive_bit(1'b1, 1'b0, 8'h00, 1'b0, f);
        begin
            exp_t e;
            e = '{is_err: 1'b1, at: f + FL + 3 + TO + 2, kc: 8'h00, mk: 1'b0, ex: 1'b0};
            sb.push_back(e);
            ext_m = 1'b0;
            brk_m = 1'b0;
        end
        ps2_data = 1'b1;
        step(TO + 10);
        send_frame(8'h1C, 1'b0);
        // 6a: short low glitch with data low must not start a frame.
        ps2_data = 1'b0;
        step(5);
        ps2_clk = 1'b0;
        step(3);
        ps2_clk = 1'b1;
        step(30);
        ps2_data = 1'b1;
        step(5);
        send_frame(8'h5A, 1'b0);
        // 6b: reset mid-frame after bit 5.
        send_frame(8'hE0, 1'b0);
        drive_bit(1'b0, 1'b0, 8'h00, 1'b0, f);
        for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b0, 8'h00, 1'b0, f);
        ps2_data = 1'b1;
        reset = 1'b0;
        #2;
        check_idle_outputs("midreset");
        step(5);
        check_idle_outputs("midreset_hold");
        ext_m = 1'b0;
        brk_m = 1'b0;
        reset = 1'b1;
        step(5);
        send_frame(8'h1C, 1'b0);
        step(50);
        check_eq("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Receives PS/2 device-to-host frames from the keyboard pins and decodes scan-code byte sequences into single key events. Its outputs are `keycode`, `make`, `keycode_ready` and `extended`. The first three drive the processor's keyboard inputs directly. The block handles synchronisation, clock-line glitch filtering, frame checking, the bus-hang timeout and the E0/F0 prefix state.

## Interface
- `FILTER_LEN`, default 8: consecutive stable `clk` samples required before the filtered PS/2 clock changes level (range 2..255).
- `TIMEOUT_CYCLES`, default 100000: idle cycles allowed between bit strobes mid-frame before the frame is abandoned (2 ms at 50 MHz).
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock pin (asynchronous).
- `ps2_data`  in  1  raw PS/2 data pin (asynchronous).
- `keycode`  out  8  last decoded scan code, excluding prefixes.
- `make`  out  1  1 = press, 0 = release (F0 prefix seen).
- `extended`  out  1  1 = E0 prefix preceded this code.
- `keycode_ready`  out  1  one-cycle pulse when a new event is presented.
- `frame_error`  out  1  one-cycle pulse on a parity, stop-bit or timeout failure.

## Operation
- **Synchronisers:** `ps2_clk` and `ps2_data` each pass through 2 flops.
- **Clock filter:**
  - A counter increments while the synced clock differs from the filtered clock, and clears when they are equal.
  - On reaching `FILTER_LEN`, the filtered clock takes the new level and the counter clears.
  - A falling edge of the filtered clock produces a 1-cycle registered strobe.
  - On the strobe, the synced data value is sampled.
- **Frame FSM, IDLE → RECV:**
  - IDLE: a strobe with data = 0 (start bit) → RECV with bit index = 1.
  - IDLE: a strobe with data = 1 is ignored, with no error.
  - RECV bits 1–8 are data, LSB first. Bit 9 is odd parity (the count of ones over data plus parity must be odd). Bit 10 is the stop bit and must be 1.
  - After bit 10 the FSM always returns to IDLE.
  - If parity and stop are both correct, an internal byte-valid is raised for 1 cycle.
  - Otherwise `frame_error` pulses and the byte is discarded.
- **Timeout:**
  - In RECV, a counter clears on each strobe and otherwise increments.
  - Reaching `TIMEOUT_CYCLES` → `frame_error` pulse, return to IDLE, discard the partial byte.
  - Not active in IDLE.
- **Decoder (runs on byte-valid):**
  - 0xE0 sets the `ext` flag. No output.
  - 0xF0 sets the `brk` flag. No output.
  - Any other byte loads `keycode` = byte, `make` = ~`brk` and `extended` = `ext`, pulses `keycode_ready`, then clears both flags.
  - Flags may be set in either order. A repeated prefix leaves its flag set.
- **Error handling:** any `frame_error` also clears `ext` and `brk`.
- **Output holding:** `keycode`, `make` and `extended` hold their value until the next event.

## Timing
- **Reset state:**
  - `keycode` = 0x00; `make`, `extended`, `keycode_ready`, `frame_error` = 0.
  - Filtered clock = 1, FSM = IDLE, all counters and flags = 0.
- **Reset mid-frame:** everything returns to the reset state immediately and the partial frame is lost. There is no output pulse on reset release.
- **Pin-to-strobe latency:** a `ps2_clk` fall that stays stable produces its strobe FILTER_LEN + 3 cycles after the pin edge: 2 synchroniser cycles, FILTER_LEN filter cycles and 1 strobe-register cycle.
- **Output latency:** with the stop-bit strobe at cycle s:
  - `frame_error` (parity or stop failure) is high at s+1 only.
  - `keycode_ready` is high at s+2 only.
  - `keycode`, `make` and `extended` are valid from s+2.
- **Timeout timing:** the timeout `frame_error` is asserted the cycle after the counter reaches `TIMEOUT_CYCLES`. If a strobe and a timeout occur in the same cycle, the strobe wins: the counter clears and no error is raised.
- **Pulse widths:** `keycode_ready` and `frame_error` are never high for 2 consecutive cycles and are never high in the same cycle.

## Test plan
1. Reset low for 5 cycles → all outputs 0. Then frame 0x1C (parity bit 0) → one `keycode_ready` pulse with `keycode` = 0x1C, `make` = 1, `extended` = 0, at exactly s+2.
2. Frames F0 then 1C → no pulse after F0, then one pulse with `keycode` = 0x1C, `make` = 0.
3. Frames E0 75 → `keycode` = 0x75, `extended` = 1, `make` = 1. Then E0 F0 75 → `extended` = 1, `make` = 0. Then 5A → `extended` = 0, `make` = 1.
4. Frame 0x1C sent with its parity bit inverted, after a preceding F0 → `frame_error` at s+1, no `keycode_ready`. Then 5A (parity 1) → `make` = 1, because `brk` was cleared by the error.
5. Send start bit + 4 data bits, hold `ps2_clk` high for `TIMEOUT_CYCLES` + 10 cycles → exactly one `frame_error`. Then a full 0x1C frame → decoded correctly.
6. With `FILTER_LEN` = 8: a 3-cycle low glitch on `ps2_clk` → no strobe and no state change. Then assert `reset` mid-frame (after bit 5), release it, and send 0x1C → outputs 0 during reset, then 0x1C decoded normally.
